// File: rtl/gsensor_spi_master.sv
// SPI mode-3 initiator for the ADXL345 accelerometer.
// Handles a single-byte register write or a 1..6 byte read burst per request.
// SCLK, CS_n and MOSI are all driven straight from flops.
module gsensor_spi_master #(
  parameter int HALF_PERIOD = 6,
  parameter int CS_GAP      = 12
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_rw,
  input  logic [5:0]  i_addr,
  input  logic [7:0]  i_wdata,
  input  logic [2:0]  i_len,
  output logic        o_busy,
  output logic        o_done,
  output logic [47:0] o_rdata,
  output logic        o_spi_cs_n,
  output logic        o_spi_sclk,
  output logic        o_spi_mosi,
  input  logic        i_spi_miso
);

  localparam int CNT_MAX = (HALF_PERIOD > CS_GAP) ? HALF_PERIOD : CS_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] HP_LAST  = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;     // clocks remaining in the current phase, counts down to 0
  logic [5:0]       bit_q;     // index of the bit on the wire, 0..55
  logic [5:0]       nbits_q;   // frame length, 16..56
  logic [15:0]      tx_q;      // header + write byte, MSB on the wire; zeros follow for reads
  logic [47:0]      rx_q;      // read bytes placed directly at their final o_rdata positions
  logic             rw_q;
  logic             miso_m_q, miso_s_q;

  logic [2:0] len_eff;
  logic [7:0] hdr;
  logic [5:0] req_nbits;
  logic [5:0] dbit;

  // Decode the request into header and frame length; dbit is the data-bit index of the current bit
  always_comb begin
    len_eff = i_len;
    if (i_len == 3'd0)      len_eff = 3'd1;
    else if (i_len > 3'd6)  len_eff = 3'd6;
    hdr       = {i_rw, i_rw && (len_eff > 3'd1), i_addr};
    req_nbits = i_rw ? ({len_eff, 3'b000} + 6'd8) : 6'd16;
    dbit      = bit_q - 6'd8;
  end

  // Two-flop synchronizer for the asynchronous SDO line
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      miso_m_q <= 1'b0;
      miso_s_q <= 1'b0;
    end else begin
      miso_m_q <= i_spi_miso;
      miso_s_q <= miso_m_q;
    end
  end

  // Transaction FSM with registered pin and handshake outputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      nbits_q    <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rw_q       <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_rdata    <= '0;
      o_spi_cs_n <= 1'b1;
      o_spi_sclk <= 1'b1;
      o_spi_mosi <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q    <= S_SETUP;
            cnt_q      <= HP_LAST;
            bit_q      <= '0;
            nbits_q    <= req_nbits;
            tx_q       <= {hdr, i_rw ? 8'h00 : i_wdata};
            rx_q       <= '0;
            rw_q       <= i_rw;
            o_busy     <= 1'b1;
            o_spi_cs_n <= 1'b0;
            o_spi_sclk <= 1'b1;
            o_spi_mosi <= hdr[7];
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            state_q    <= S_SHIFT;
            cnt_q      <= HP_LAST;
            o_spi_sclk <= 1'b0;
            o_spi_mosi <= tx_q[15];
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_SHIFT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_ONE;
          end else if (!o_spi_sclk) begin
            // Rising edge: capture the synchronized SDO bit, MSB-first within its byte
            o_spi_sclk <= 1'b1;
            cnt_q      <= HP_LAST;
            if (rw_q && (bit_q >= 6'd8))
              rx_q[{dbit[5:3], ~dbit[2:0]}] <= miso_s_q;
          end else if (bit_q == nbits_q - 6'd1) begin
            state_q <= S_HOLD;
            cnt_q   <= HP_LAST;
          end else begin
            // Falling edge: advance to the next bit
            o_spi_sclk <= 1'b0;
            cnt_q      <= HP_LAST;
            bit_q      <= bit_q + 6'd1;
            tx_q       <= {tx_q[14:0], 1'b0};
            o_spi_mosi <= tx_q[14];
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_q    <= S_GAP;
            cnt_q      <= GAP_LAST;
            o_spi_cs_n <= 1'b1;
            o_spi_mosi <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_GAP: begin
          if (cnt_q == '0) begin
            state_q <= S_DONE;
            o_done  <= 1'b1;
            o_rdata <= rw_q ? rx_q : 48'h0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          o_busy  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gsensor_spi_master.sv
// Bench for gsensor_spi_master: timeline model of the SPI waveform, ADXL345 responder,
// and directed transactions with hand-computed headers, latencies and read data.
module tb_gsensor_spi_master;
  localparam int HP  = 6;
  localparam int GAP = 12;

  logic clk = 1'b0;
  logic rst, start, rw, miso;
  logic [5:0] addr;
  logic [7:0] wdata;
  logic [2:0] len;
  logic busy, done, cs_n, sclk, mosi;
  logic [47:0] rdata;

  gsensor_spi_master #(.HALF_PERIOD(HP), .CS_GAP(GAP)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_rw(rw), .i_addr(addr),
    .i_wdata(wdata), .i_len(len), .o_busy(busy), .o_done(done), .o_rdata(rdata),
    .o_spi_cs_n(cs_n), .o_spi_sclk(sclk), .o_spi_mosi(mosi), .i_spi_miso(miso)
  );

  always #10 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- model of one transaction as a timeline ----------------
  bit          mact = 1'b0;   // a transaction is in flight
  bit          cmp_en = 1'b0;
  int          mt, m_L, m_bits;
  logic        m_rw;
  logic [7:0]  m_hdr, m_wd;
  logic [47:0] m_rd, exp_rdata = '0;
  logic [7:0]  resp [6];

  function automatic logic fbit(input int i);
    if (i < 8) return m_hdr[7-i];
    if (m_rw)  return 1'b0;
    return m_wd[15-i];
  endfunction

  // ---------------- monitor state ----------------
  logic        p_cs = 1'b1, p_mosi = 1'b0;
  int          cs_fall_cyc = 0, lat = -1, done_cnt = 0, rises = 0;
  logic [63:0] cap = '0;

  // Per-cycle comparison of every output against the timeline, plus mode-3 rules
  always @(negedge clk) begin
    logic e_cs, e_sclk, e_busy, e_done;
    int u;
    cyc++;
    if (cmp_en) begin
      e_cs = 1'b1; e_sclk = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      if (mact) begin
        mt++;
        e_busy = 1'b1;
        if (mt <= m_L) begin
          e_cs = 1'b0;
          u = mt - 1 - HP;
          if (u >= 0 && u < 2*HP*m_bits) e_sclk = ((u / HP) % 2) == 1;
          if (u < 2*HP*m_bits) chk("mosi_bit", 64'(mosi), 64'(fbit(u < 0 ? 0 : u / (2*HP))));
        end else if (mt == m_L + GAP + 1) begin
          e_done = 1'b1;
          exp_rdata = m_rd;
          mact = 1'b0;
        end
      end
      chk("cs_n",  64'(cs_n),  64'(e_cs));
      chk("sclk",  64'(sclk),  64'(e_sclk));
      chk("busy",  64'(busy),  64'(e_busy));
      chk("done",  64'(done),  64'(e_done));
      chk("rdata", 64'(rdata), 64'(exp_rdata));
      if (mosi !== p_mosi) chk("mode3_mosi_change", 64'(!sclk || cs_n || p_cs), 64'(1));
      if (cs_n) chk("mode3_sclk_idle", 64'(sclk), 64'(1));
      if (!cs_n && p_cs) cs_fall_cyc = cyc;
      if (done) begin lat = cyc - cs_fall_cyc; done_cnt++; end
      p_cs = cs_n; p_mosi = mosi;
    end
  end

  // Capture MOSI on every SCLK rise inside a frame
  always @(negedge cs_n) begin rises = 0; cap = '0; end
  always @(posedge sclk) if (cs_n === 1'b0) begin cap = {cap[62:0], mosi}; rises++; end

  // ADXL345 responder: shifts SDO on SCLK falling edges, junk ones during the header
  int sl_bit = 0;
  always @(negedge cs_n) sl_bit = 0;
  always @(negedge sclk) if (cs_n === 1'b0) begin
    int b;
    logic v;
    b = sl_bit;
    sl_bit++;
    if (b < 8) v = 1'b1;
    else       v = resp[(b-8)/8][7-((b-8)%8)];
    #2 miso = v;
  end

  // Drive one request and arm the model
  task automatic launch(input logic t_rw, input logic [5:0] t_addr, input logic [7:0] t_wd,
                        input logic [2:0] t_len);
    int n;
    @(negedge clk); #1;
    n = (t_len == 0) ? 1 : ((t_len > 6) ? 6 : int'(t_len));
    m_rw   = t_rw;
    m_hdr  = {t_rw, t_rw && (n > 1), t_addr};
    m_wd   = t_wd;
    m_bits = t_rw ? 8 + 8*n : 16;
    m_L    = HP * (2 + 2*m_bits);
    m_rd   = '0;
    if (t_rw) for (int i = 0; i < n; i++) m_rd[8*i +: 8] = resp[i];
    lat = -1; done_cnt = 0;
    rw = t_rw; addr = t_addr; wdata = t_wd; len = t_len; start = 1'b1;
    mt = 0; mact = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    rw = ~t_rw; addr = ~t_addr; wdata = ~t_wd; len = ~t_len;  // must not affect the frame
  endtask

  task automatic txn(input string nm, input logic t_rw, input logic [5:0] t_addr,
                     input logic [7:0] t_wd, input logic [2:0] t_len,
                     input logic [7:0] x_hdr, input logic [7:0] x_tail, input int x_bits,
                     input int x_lat, input logic [47:0] x_rd, input bit stray, input bit in_done);
    logic [63:0] sh;
    launch(t_rw, t_addr, t_wd, t_len);
    if (stray) begin
      repeat (50) @(negedge clk);
      #1 start = 1'b1;
      @(negedge clk); #1 start = 1'b0;
    end
    for (int i = 0; i < 3000 && mact; i++) begin @(negedge clk); #1; end
    if (in_done) begin
      start = 1'b1;                       // lands in the o_done cycle
      @(negedge clk); #1 start = 1'b0;
    end
    repeat (4) @(negedge clk);
    #1;
    sh = cap >> (rises - 8);
    chk($sformatf("%s_done_count", nm), 64'(done_cnt), 64'(1));
    chk($sformatf("%s_latency", nm),    64'(lat),      64'(x_lat));
    chk($sformatf("%s_rises", nm),      64'(rises),    64'(x_bits));
    chk($sformatf("%s_header", nm),     64'(sh[7:0]),  64'(x_hdr));
    chk($sformatf("%s_tail", nm),       64'(cap[7:0]), 64'(x_tail));
    chk($sformatf("%s_rdata", nm),      64'(rdata),    64'(x_rd));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; len = '0; miso = 1'b0;
    for (int i = 0; i < 6; i++) resp[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_cs_n",  64'(cs_n),  64'(1));
    chk("reset_sclk",  64'(sclk),  64'(1));
    chk("reset_mosi",  64'(mosi),  64'(0));
    chk("reset_busy",  64'(busy),  64'(0));
    chk("reset_done",  64'(done),  64'(0));
    chk("reset_rdata", 64'(rdata), 64'(0));
    #1 rst = 1'b0; cmp_en = 1'b1;

    // single-byte write
    txn("write", 1'b0, 6'h2D, 8'h08, 3'd0, 8'h2D, 8'h08, 16, 216, 48'h0, 1'b0, 1'b1);

    // single read
    resp[0] = 8'hE5;
    txn("read1", 1'b1, 6'h00, 8'h00, 3'd1, 8'h80, 8'h00, 16, 216, 48'hE5, 1'b0, 1'b0);

    // 6-byte burst with a stray start mid-frame
    for (int i = 0; i < 6; i++) resp[i] = 8'(8'h11 * (i + 1));
    txn("burst6", 1'b1, 6'h32, 8'h00, 3'd6, 8'hF2, 8'h00, 56, 696, 48'h6655_4433_2211, 1'b1, 1'b0);

    // len 0 behaves as 1
    resp[0] = 8'hA7;
    txn("len0", 1'b1, 6'h05, 8'hFF, 3'd0, 8'h85, 8'h00, 16, 216, 48'hA7, 1'b0, 1'b0);

    // len 7 clamps to 6
    for (int i = 0; i < 6; i++) resp[i] = 8'(8'hC1 + i);
    txn("len7", 1'b1, 6'h32, 8'h00, 3'd7, 8'hF2, 8'h00, 56, 696, 48'hC6C5_C4C3_C2C1, 1'b0, 1'b0);

    // 3-byte read
    resp[0] = 8'h3C; resp[1] = 8'h5A; resp[2] = 8'h96;
    txn("len3", 1'b1, 6'h1E, 8'h00, 3'd3, 8'hDE, 8'h00, 32, 408, 48'h96_5A3C, 1'b0, 1'b0);

    // reset during bit 20 of a burst
    launch(1'b1, 6'h32, 8'h00, 3'd6);
    for (int i = 0; i < 2000 && mt < HP + 2*HP*20 + 3; i++) begin @(negedge clk); #1; end
    rst = 1'b1; mact = 1'b0; exp_rdata = '0;
    @(negedge clk); #1;
    chk("midrst_cs_n", 64'(cs_n), 64'(1));
    chk("midrst_sclk", 64'(sclk), 64'(1));
    chk("midrst_mosi", 64'(mosi), 64'(0));
    chk("midrst_busy", 64'(busy), 64'(0));
    rst = 1'b0;
    repeat (800) @(negedge clk);
    #1 chk("midrst_no_done", 64'(done_cnt), 64'(0));

    // read after the aborted burst
    resp[0] = 8'hE5;
    txn("read_after_rst", 1'b1, 6'h00, 8'h00, 3'd1, 8'h80, 8'h00, 16, 216, 48'hE5, 1'b0, 1'b0);

    // reset and start together: reset wins
    @(negedge clk); #1;
    rst = 1'b1; start = 1'b1; rw = 1'b1; len = 3'd1; exp_rdata = '0; done_cnt = 0;
    @(negedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", 64'(busy), 64'(0));
    chk("rst_start_cs_n", 64'(cs_n), 64'(1));
    repeat (300) @(negedge clk);
    #1 chk("rst_start_no_done", 64'(done_cnt), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
